chip8_mem_arbiter: RTL and testbench

//  Shares the single-port 4 KiB CHIP-8 RAM between the CPU (fetch, FX33/FX55/FX65) and the video scanout/sprite reader.

---
 rtl/chip8_mem_arbiter.sv | 119 +++++++++++
 tb/tb_chip8_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem_arbiter.sv
// Arbitrates the single-port CHIP-8 RAM between the CPU and the video reader.
// One access per clock, registered RAM command, read data returned two edges after accept.
module chip8_mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter bit          VID_PRIO = 1'b1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [7:0]        vid_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {
    WIN_CPU = 1'b0,
    WIN_VID = 1'b1
  } winner_e;

  winner_e          last_winner;
  logic [CNT_W-1:0] cpu_wait;
  logic [CNT_W-1:0] vid_wait;
  logic [CNT_W-1:0] cpu_wait_d;
  logic [CNT_W-1:0] vid_wait_d;
  logic             cpu_acc;
  logic             vid_acc;
  logic             cpu_rd_tag;
  logic             vid_rd_tag;

  // Grant decision: depends only on current requests and registered arbiter state
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (reset) begin
      if (cpu_req && vid_req) begin
        if (cpu_wait == WAIT_MAX) begin
          cpu_gnt = 1'b1;
        end else if (vid_wait == WAIT_MAX) begin
          vid_gnt = 1'b1;
        end else if (VID_PRIO) begin
          vid_gnt = 1'b1;
        end else if (last_winner == WIN_VID) begin
          cpu_gnt = 1'b1;
        end else begin
          vid_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        vid_gnt = vid_req;
      end
    end
  end

  // Starvation counters: count consecutive losses, saturate, clear on grant or idle
  always_comb begin
    cpu_acc    = cpu_req && cpu_gnt;
    vid_acc    = vid_req && vid_gnt;
    cpu_wait_d = '0;
    vid_wait_d = '0;
    if (cpu_req && !cpu_gnt) begin
      cpu_wait_d = (cpu_wait == WAIT_MAX) ? cpu_wait : cpu_wait + CNT_W'(1);
    end
    if (vid_req && !vid_gnt) begin
      vid_wait_d = (vid_wait == WAIT_MAX) ? vid_wait : vid_wait + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= WIN_VID;
      cpu_wait    <= '0;
      vid_wait    <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      cpu_rd_tag  <= 1'b0;
      vid_rd_tag  <= 1'b0;
      cpu_rvalid  <= 1'b0;
      vid_rvalid  <= 1'b0;
    end else begin
      cpu_wait   <= cpu_wait_d;
      vid_wait   <= vid_wait_d;
      mem_we     <= cpu_acc && cpu_we;
      cpu_rd_tag <= cpu_acc && !cpu_we;
      vid_rd_tag <= vid_acc;
      cpu_rvalid <= cpu_rd_tag;
      vid_rvalid <= vid_rd_tag;
      if (cpu_acc) begin
        mem_addr    <= cpu_addr;
        mem_wdata   <= cpu_wdata;
        last_winner <= WIN_CPU;
      end else if (vid_acc) begin
        mem_addr    <= vid_addr;
        last_winner <= WIN_VID;
      end
    end
  end

  // RAM output fans out to both ports; rvalid selects the owner
  assign cpu_rdata = mem_rdata;
  assign vid_rdata = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: a video-priority and a round-robin instance
// share the stimulus, each backed by its own synchronous RAM model.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vid_req;
  logic [11:0] cpu_addr, vid_addr;
  logic [7:0]  cpu_wdata;

  logic        p_cpu_gnt, p_cpu_rvalid, p_vid_gnt, p_vid_rvalid, p_mem_we;
  logic [7:0]  p_cpu_rdata, p_vid_rdata, p_mem_wdata, p_mem_rdata;
  logic [11:0] p_mem_addr;
  logic        r_cpu_gnt, r_cpu_rvalid, r_vid_gnt, r_vid_rvalid, r_mem_we;
  logic [7:0]  r_cpu_rdata, r_vid_rdata, r_mem_wdata, r_mem_rdata;
  logic [11:0] r_mem_addr;

  logic [7:0] ram_p [4096];
  logic [7:0] ram_r [4096];
  logic       ram_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       c_req;
    logic       v_req;
    logic [1:0] p_exp;   // {cpu_gnt, vid_gnt} of the video-priority instance
    logic [1:0] r_exp;   // {cpu_gnt, vid_gnt} of the round-robin instance
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(12), .VID_PRIO(1'b1), .MAX_WAIT(4)) u_dut_p (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(p_cpu_gnt), .cpu_rvalid(p_cpu_rvalid), .cpu_rdata(p_cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(p_vid_gnt), .vid_rvalid(p_vid_rvalid), .vid_rdata(p_vid_rdata),
    .mem_addr(p_mem_addr), .mem_we(p_mem_we), .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata)
  );

  chip8_mem_arbiter #(.ADDR_W(12), .VID_PRIO(1'b0), .MAX_WAIT(4)) u_dut_r (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(r_cpu_gnt), .cpu_rvalid(r_cpu_rvalid), .cpu_rdata(r_cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(r_vid_gnt), .vid_rvalid(r_vid_rvalid), .vid_rdata(r_vid_rdata),
    .mem_addr(r_mem_addr), .mem_we(r_mem_we), .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata)
  );

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous RAMs, preloaded with a known pattern on the first edge
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < 4096; a++) begin
        ram_p[a] <= pat(12'(a));
        ram_r[a] <= pat(12'(a));
      end
      ram_ready <= 1'b1;
    end else begin
      if (p_mem_we) ram_p[p_mem_addr] <= p_mem_wdata;
      if (r_mem_we) ram_r[r_mem_addr] <= r_mem_wdata;
      p_mem_rdata <= ram_p[p_mem_addr];
      r_mem_rdata <= ram_r[r_mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    cpu_we  = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        prev_c, prev_v;
    logic [11:0] exp_addr, prev_addr;

    tbl[0]  = '{1'b1, 1'b0, 2'b10, 2'b10};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 2'b01};
    tbl[2]  = '{1'b1, 1'b1, 2'b01, 2'b10};
    tbl[3]  = '{1'b1, 1'b1, 2'b01, 2'b01};
    tbl[4]  = '{1'b1, 1'b1, 2'b01, 2'b10};
    tbl[5]  = '{1'b1, 1'b1, 2'b01, 2'b01};
    tbl[6]  = '{1'b1, 1'b1, 2'b10, 2'b10};
    tbl[7]  = '{1'b1, 1'b1, 2'b01, 2'b01};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 1'b1, 2'b01, 2'b10};
    tbl[10] = '{1'b1, 1'b0, 2'b10, 2'b10};
    tbl[11] = '{1'b1, 1'b1, 2'b01, 2'b01};
    tbl[12] = '{1'b1, 1'b1, 2'b01, 2'b10};
    tbl[13] = '{1'b1, 1'b1, 2'b01, 2'b01};
    tbl[14] = '{1'b1, 1'b1, 2'b01, 2'b10};
    tbl[15] = '{1'b1, 1'b1, 2'b10, 2'b01};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 2'b00};

    // Reset held with both requests high
    reset     = 1'b0;
    cpu_req   = 1'b1;
    vid_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 12'h123;
    cpu_wdata = 8'h00;
    vid_addr  = 12'h045;
    repeat (3) step();
    chk("rst_p_gnt", 32'({p_cpu_gnt, p_vid_gnt}), 32'(0));
    chk("rst_r_gnt", 32'({r_cpu_gnt, r_vid_gnt}), 32'(0));
    chk("rst_mem_we", 32'(p_mem_we), 32'(0));
    chk("rst_mem_addr", 32'(p_mem_addr), 32'(0));
    chk("rst_rvalid", 32'({p_cpu_rvalid, p_vid_rvalid, r_cpu_rvalid, r_vid_rvalid}), 32'(0));
    reset = 1'b1;
    #1;
    chk("rel_p_gnt", 32'({p_cpu_gnt, p_vid_gnt}), 32'(2'b01));
    chk("rel_r_gnt", 32'({r_cpu_gnt, r_vid_gnt}), 32'(2'b10));
    step();
    chk("rel_p_addr", 32'(p_mem_addr), 32'(12'h045));
    chk("rel_r_addr", 32'(r_mem_addr), 32'(12'h123));
    cpu_req = 1'b0;
    vid_req = 1'b0;
    step();
    chk("rel_p_vid_rvalid", 32'({p_cpu_rvalid, p_vid_rvalid}), 32'(2'b01));
    chk("rel_p_vid_rdata", 32'(p_vid_rdata), 32'(pat(12'h045)));
    step();
    chk("rel_rvalid_pulse", 32'({p_cpu_rvalid, p_vid_rvalid}), 32'(0));

    // Arbitration table, reads only, from a clean reset
    do_reset();
    prev_c    = 1'b0;
    prev_v    = 1'b0;
    prev_addr = '0;
    exp_addr  = '0;
    for (int i = 0; i < NVEC; i++) begin
      cpu_req  = tbl[i].c_req;
      vid_req  = tbl[i].v_req;
      cpu_addr = 12'h100 + 12'(i);
      vid_addr = 12'h040 + 12'(i);
      #1;
      chk($sformatf("tbl%0d_p_gnt", i), 32'({p_cpu_gnt, p_vid_gnt}), 32'(tbl[i].p_exp));
      chk($sformatf("tbl%0d_r_gnt", i), 32'({r_cpu_gnt, r_vid_gnt}), 32'(tbl[i].r_exp));
      step();
      if (tbl[i].p_exp[1]) exp_addr = cpu_addr;
      else if (tbl[i].p_exp[0]) exp_addr = vid_addr;
      chk($sformatf("tbl%0d_mem_addr", i), 32'(p_mem_addr), 32'(exp_addr));
      chk($sformatf("tbl%0d_mem_we", i), 32'(p_mem_we), 32'(0));
      chk($sformatf("tbl%0d_rvalid", i), 32'({p_cpu_rvalid, p_vid_rvalid}), 32'({prev_c, prev_v}));
      if (prev_c) chk($sformatf("tbl%0d_cpu_rdata", i), 32'(p_cpu_rdata), 32'(pat(prev_addr)));
      if (prev_v) chk($sformatf("tbl%0d_vid_rdata", i), 32'(p_vid_rdata), 32'(pat(prev_addr)));
      prev_c    = tbl[i].p_exp[1];
      prev_v    = tbl[i].p_exp[0];
      prev_addr = exp_addr;
    end

    // Write then consecutive read of the same address
    do_reset();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 12'h200;
    cpu_wdata = 8'hA5;
    #1;
    chk("wr_gnt", 32'(p_cpu_gnt), 32'(1));
    step();
    chk("wr_mem", 32'({p_mem_we, p_mem_addr, p_mem_wdata}), 32'({1'b1, 12'h200, 8'hA5}));
    cpu_we = 1'b0;
    #1;
    chk("raw_gnt", 32'(p_cpu_gnt), 32'(1));
    step();
    chk("raw_mem_we", 32'(p_mem_we), 32'(0));
    chk("wr_no_rvalid", 32'(p_cpu_rvalid), 32'(0));
    cpu_req = 1'b0;
    step();
    chk("raw_rvalid", 32'({p_cpu_rvalid, p_vid_rvalid}), 32'(2'b10));
    chk("raw_rdata", 32'(p_cpu_rdata), 32'(8'hA5));
    step();
    chk("raw_rvalid_pulse", 32'(p_cpu_rvalid), 32'(0));

    // Write 0x3C @0x300, read back through the video port
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 12'h300;
    cpu_wdata = 8'h3C;
    step();
    chk("wr2_mem", 32'({p_mem_we, p_mem_addr, p_mem_wdata}), 32'({1'b1, 12'h300, 8'h3C}));
    cpu_req = 1'b0;
    step();
    chk("wr2_we_pulse", 32'(p_mem_we), 32'(0));
    chk("wr2_no_rvalid_a", 32'(p_cpu_rvalid), 32'(0));
    step();
    chk("wr2_no_rvalid_b", 32'(p_cpu_rvalid), 32'(0));
    // A losing CPU write must not leak a write strobe
    cpu_req   = 1'b1;
    cpu_addr  = 12'h3FF;
    cpu_wdata = 8'hEE;
    vid_req   = 1'b1;
    vid_addr  = 12'h300;
    #1;
    chk("vrd_p_gnt", 32'({p_cpu_gnt, p_vid_gnt}), 32'(2'b01));
    chk("vrd_r_gnt", 32'({r_cpu_gnt, r_vid_gnt}), 32'(2'b01));
    step();
    chk("vrd_mem", 32'({p_mem_we, p_mem_addr}), 32'({1'b0, 12'h300}));
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    vid_req = 1'b0;
    step();
    chk("vrd_rvalid", 32'({p_cpu_rvalid, p_vid_rvalid}), 32'(2'b01));
    chk("vrd_rdata", 32'(p_vid_rdata), 32'(8'h3C));

    // Reset while a CPU read is in flight
    step();
    cpu_req  = 1'b1;
    cpu_addr = 12'h200;
    step();
    cpu_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'({p_cpu_rvalid, r_cpu_rvalid}), 32'(0));
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_rvalid%0d", i),
          32'({p_cpu_rvalid, p_vid_rvalid, r_cpu_rvalid, r_vid_rvalid}), 32'(0));
    end
    // Counters and last_winner restart from reset values
    cpu_req = 1'b1;
    vid_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("post_rst_p_gnt%0d", i), 32'({p_cpu_gnt, p_vid_gnt}),
          (i == 4) ? 32'(2'b10) : 32'(2'b01));
      chk($sformatf("post_rst_r_gnt%0d", i), 32'({r_cpu_gnt, r_vid_gnt}),
          (i % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
      step();
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
